// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store unit and the data memory.
// Signal names keep their _i/_o suffixes as seen from the memory side.
interface dmem_responder_if;
    logic [15:0] mem_addr_i;
    logic        mem_read_en_i;
    logic        mem_write_en_i;
    logic [15:0] mem_write_data_i;
    logic [15:0] mem_read_data_o;
    logic        dcache_valid_o;

    modport master (
        output mem_addr_i, mem_read_en_i, mem_write_en_i, mem_write_data_i,
        input  mem_read_data_o, dcache_valid_o
    );

    modport slave (
        input  mem_addr_i, mem_read_en_i, mem_write_en_i, mem_write_data_i,
        output mem_read_data_o, dcache_valid_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port 16-bit data memory answering level-held LSU loads after a fixed
// READ_LAT, with dcache_valid_o used by the LSU as its load stall signal.
module dmem_responder #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT =
        (READ_LAT >= 2) ? CNT_W'(READ_LAT - 2) : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    lat_cnt, lat_cnt_n;
    logic [ADDR_W-1:0]   req_addr;
    logic [15:0]         rd_data;
    logic [15:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   cap_addr;
    logic                addr_match;
    logic                latch_addr;
    logic                capture;

    assign addr       = bus.mem_addr_i[ADDR_W-1:0];
    assign addr_match = (addr == req_addr);

    // Upper address bits alias onto the lower words and are intentionally ignored.
    generate
        if (ADDR_W < 16) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.mem_addr_i[15:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_n;
            lat_cnt <= lat_cnt_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        lat_cnt_n  = lat_cnt;
        latch_addr = 1'b0;
        capture    = 1'b0;
        cap_addr   = req_addr;

        unique case (state)
            IDLE: begin
                if (bus.mem_read_en_i) begin
                    latch_addr = 1'b1;
                    if (READ_LAT == 1) begin
                        state_n  = DONE;
                        capture  = 1'b1;
                        cap_addr = addr;
                    end else begin
                        state_n   = WAIT;
                        lat_cnt_n = LAT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.mem_read_en_i) begin
                    state_n = IDLE;
                end else if (!addr_match) begin
                    latch_addr = 1'b1;
                    lat_cnt_n  = LAT_INIT;
                end else if (lat_cnt == '0) begin
                    state_n = DONE;
                    capture = 1'b1;
                end else begin
                    lat_cnt_n = lat_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (!bus.mem_read_en_i) begin
                    state_n = IDLE;
                end else if (!addr_match) begin
                    latch_addr = 1'b1;
                    if (READ_LAT == 1) begin
                        capture  = 1'b1;
                        cap_addr = addr;
                    end else begin
                        state_n   = WAIT;
                        lat_cnt_n = LAT_INIT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_addr <= '0;
            rd_data  <= '0;
        end else begin
            if (latch_addr) req_addr <= addr;
            if (capture)    rd_data  <= mem[cap_addr];
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM and keeps its contents across rst_i.
    always_ff @(posedge clk_i) begin
        if (bus.mem_write_en_i && !bus.mem_read_en_i) begin
            mem[addr] <= bus.mem_write_data_i;
        end
    end

    assign bus.mem_read_data_o = rd_data;
    assign bus.dcache_valid_o  = !bus.mem_read_en_i || (state == DONE && addr_match);
endmodule
